// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream datapath among C_NUM_INPUTS slaves.
// Optional per-stream packet counters are enabled with `define NF10_AXIS_ARB_PKT_COUNT_EN.
module nf10_axis_rr_arbiter #(
  parameter int C_NUM_INPUTS       = 4,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                           axi_aclk,
  input  logic                                           axi_resetn,
  input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_NUM_INPUTS*(C_AXIS_DATA_WIDTH/8)-1:0]  s_axis_tstrb,
  input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]                        s_axis_tready,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]                   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                 m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                  m_axis_tuser,
  output logic                                           m_axis_tvalid,
  input  logic                                           m_axis_tready,
  output logic                                           m_axis_tlast
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
  ,
  output logic [C_NUM_INPUTS*32-1:0]                     pkt_count
`endif
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int IW = $clog2(C_NUM_INPUTS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [IW-1:0]   pick, cand;
  logic            hit;
  logic            pkt_end;

  logic [C_AXIS_DATA_WIDTH-1:0]  data_arr [C_NUM_INPUTS];
  logic [SW-1:0]                 strb_arr [C_NUM_INPUTS];
  logic [C_AXIS_TUSER_WIDTH-1:0] user_arr [C_NUM_INPUTS];

  for (genvar gi = 0; gi < C_NUM_INPUTS; gi++) begin : g_lane
    assign data_arr[gi]      = s_axis_tdata[gi*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign strb_arr[gi]      = s_axis_tstrb[gi*SW +: SW];
    assign user_arr[gi]      = s_axis_tuser[gi*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    assign s_axis_tready[gi] = (state_reg == GRANT) && (gnt_reg == IW'(gi)) && m_axis_tready;
  end

  // Rotating search: first valid stream starting just after the last one served.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 1; k <= C_NUM_INPUTS; k++) begin
      cand = IW'((int'(last_reg) + k) % C_NUM_INPUTS);
      if (!hit && s_axis_tvalid[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state_reg == GRANT) begin
      m_axis_tdata  = data_arr[gnt_reg];
      m_axis_tstrb  = strb_arr[gnt_reg];
      m_axis_tuser  = user_arr[gnt_reg];
      m_axis_tvalid = s_axis_tvalid[gnt_reg];
      m_axis_tlast  = s_axis_tlast[gnt_reg];
    end
  end

  assign pkt_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          state_next = GRANT;
          gnt_next   = pick;
          last_next  = pick;
        end
      end
      GRANT: begin
        if (pkt_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= IW'(C_NUM_INPUTS - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
  for (genvar gi = 0; gi < C_NUM_INPUTS; gi++) begin : g_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        cnt_reg <= '0;
      end else if (pkt_end && (gnt_reg == IW'(gi))) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign pkt_count[gi*32 +: 32] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// Scoreboard bench for nf10_axis_rr_arbiter: sources per stream, expected beats queued in grant order.
// Counter checks compile only when NF10_AXIS_ARB_PKT_COUNT_EN is defined.
module tb_nf10_axis_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic             axi_aclk = 1'b0;
  logic             axi_resetn = 1'b0;
  logic [N*64-1:0]  s_axis_tdata = '0;
  logic [N*8-1:0]   s_axis_tstrb = '0;
  logic [N*128-1:0] s_axis_tuser = '0;
  logic [N-1:0]     s_axis_tvalid = '0;
  logic [N-1:0]     s_axis_tready;
  logic [N-1:0]     s_axis_tlast = '0;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tstrb;
  logic [127:0]     m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             m_axis_tlast;
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
  logic [N*32-1:0]  pkt_count;
`endif

  nf10_axis_rr_arbiter dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  beat_t    src_q [N][$];
  beat_t    exp_q [$];
  int       beat_log [$];
  int       served [N];
  logic [N-1:0] acc  = '0;
  logic [N-1:0] hold = '0;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;

  function automatic beat_t mk(int s, int p, int b, int len);
    beat_t r;
    r.d = {8'(s), 8'(p), 16'hC0DE, 24'(p * 7 + s), 8'(b + 1)};
    r.k = (b == len - 1) ? 8'hA5 : 8'hFF;
    r.u = {8'(s), 8'(p), 8'(len), 8'hEE, 96'h123456789ABCDEF00F1E2D3C};
    r.l = (b == len - 1);
    return r;
  endfunction

  task automatic add_src(input int s, input int p, input int len);
    for (int b = 0; b < len; b++) src_q[s].push_back(mk(s, p, b, len));
  endtask

  task automatic add_exp(input int s, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk(s, p, b, len));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_axis_tdata[i*64 +: 64]   = src_q[i][0].d;
        s_axis_tstrb[i*8 +: 8]     = src_q[i][0].k;
        s_axis_tuser[i*128 +: 128] = src_q[i][0].u;
        s_axis_tlast[i]            = src_q[i][0].l;
        s_axis_tvalid[i]           = 1'b1;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tlast[i]  = 1'b0;
      end
    end
  endtask

  // Pops the expected beat whenever the output handshakes.
  task automatic monitor();
    beat_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got tdata=%h, required no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} !== e) begin
          errors++;
          $display("FAIL beat: got d=%h k=%h u=%h l=%b, required d=%h k=%h u=%h l=%b",
                   m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, e.d, e.k, e.u, e.l);
        end
      end
      beat_log.push_back(cyc);
      if (m_axis_tlast) served[m_axis_tdata[57:56]]++;
    end
  endtask

  task automatic cycle(input bit rdy);
    @(posedge axi_aclk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
    m_axis_tready = rdy;
    cyc++;
    @(negedge axi_aclk);
    acc = s_axis_tvalid & s_axis_tready;
    monitor();
  endtask

  task automatic run(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle(1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
    end
    cycle(1'b1);
  endtask

  task automatic pulse_reset();
    axi_resetn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    acc  = '0;
    hold = '0;
    drive();
    cycle(1'b1);
    axi_resetn = 1'b1;
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0;
    #12;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tready=%b tlast=%b tdata=%h, required 0 0000 0 0",
               m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tdata);
    end
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d got tvalid=%b tready=%b, required 0 0000", i, m_axis_tvalid, s_axis_tready);
      end
    end
  endtask

  task automatic test_single_stream();
    add_src(2, 1, 4);
    add_exp(2, 1, 4);
    cycle(1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL arb_latency_early: got tvalid=%b, required 0", m_axis_tvalid);
    end
    cycle(1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 4'b0100) begin
      errors++;
      $display("FAIL arb_latency: got tvalid=%b tready=%b, required 1 0100", m_axis_tvalid, s_axis_tready);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      cycle(1'b1);
      checks++;
      if (s_axis_tready !== 4'b0100) begin
        errors++;
        $display("FAIL single_tready: got %b, required 0100", s_axis_tready);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    cycle(1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || m_axis_tdata !== 64'h0) begin
      errors++;
      $display("FAIL single_idle: got tvalid=%b tready=%b tdata=%h, required 0 0000 0", m_axis_tvalid, s_axis_tready, m_axis_tdata);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) begin
        add_src(s, 10 + p, 3);
        add_exp(s, 10 + p, 3);
      end
    beat_log.delete();
    for (int s = 0; s < N; s++) served[s] = 0;
    run(80, "rr");
    checks++;
    if (beat_log.size() != 24 || beat_log[23] - beat_log[0] != 30) begin
      errors++;
      $display("FAIL rr_span: got %0d beats over %0d cycles, required 24 over 30",
               beat_log.size(), (beat_log.size() > 0) ? beat_log[beat_log.size()-1] - beat_log[0] : -1);
    end else begin
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (beat_log[3*k] - beat_log[3*k-1] != 2) begin
          errors++;
          $display("FAIL rr_gap: packet %0d got gap %0d, required 2", k, beat_log[3*k] - beat_log[3*k-1]);
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      checks++;
      if (served[s] != 2) begin
        errors++;
        $display("FAIL rr_fair: stream %0d got %0d packets, required 2", s, served[s]);
      end
    end
  endtask

  task automatic test_hold_toggle();
    int n = 0;
    add_src(0, 20, 6);
    add_exp(0, 20, 6);
    cycle(1'b1);
    add_src(1, 21, 3);
    add_exp(1, 21, 3);
    while (exp_q.size() > 0 && n < 60) begin
      hold[0] = (n == 4 || n == 5);
      cycle((cyc % 2) == 0);
      if (n == 4 || n == 5) begin
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready[1] !== 1'b0) begin
          errors++;
          $display("FAIL hold_wait: got tvalid=%b tready=%b, required 0 with stream 1 not ready", m_axis_tvalid, s_axis_tready);
        end
      end
      n++;
    end
    hold = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    cycle(1'b1);
  endtask

  task automatic test_reset_midpkt();
    int n = 0;
    add_src(0, 30, 5);
    add_exp(0, 30, 5);
    beat_log.delete();
    while (beat_log.size() < 2 && n < 20) begin
      cycle(1'b1);
      n++;
    end
    checks++;
    if (beat_log.size() != 2) begin
      errors++;
      $display("FAIL rst_mid_timeout: got %0d beats, required 2", beat_log.size());
    end
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got tvalid=%b tready=%b tlast=%b tdata=%h, required 0 0000 0 0",
               m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tdata);
    end
    src_q[0].delete();
    exp_q.delete();
    acc = '0;
    drive();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_hold: got tvalid=%b, required 0", m_axis_tvalid);
      end
    end
    axi_resetn = 1'b1;
    add_src(1, 31, 3);
    add_src(0, 32, 2);
    add_exp(0, 32, 2);
    add_exp(1, 31, 3);
    run(40, "rst_mid");
  endtask

`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
  task automatic test_pkt_count();
    pulse_reset();
    for (int p = 0; p < 5; p++) begin
      add_src(3, 40 + p, 1);
      add_exp(3, 40 + p, 1);
    end
    run(60, "cnt");
    for (int s = 0; s < N; s++) begin
      checks++;
      if (pkt_count[s*32 +: 32] !== ((s == 3) ? 32'd5 : 32'd0)) begin
        errors++;
        $display("FAIL pkt_count: stream %0d got %0d, required %0d", s, pkt_count[s*32 +: 32], (s == 3) ? 5 : 0);
      end
    end
    force dut.g_cnt[3].cnt_reg = 32'hFFFF_FFFF;
    cycle(1'b1);
    release dut.g_cnt[3].cnt_reg;
    add_src(3, 50, 1);
    add_exp(3, 50, 1);
    run(20, "cnt_wrap");
    checks++;
    if (pkt_count[3*32 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL pkt_count_wrap: got %h, required 0", pkt_count[3*32 +: 32]);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_hold_toggle();
    test_reset_midpkt();
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
    test_pkt_count();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d expected beats unseen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_axis_rr_arbiter.md
# nf10_axis_rr_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream datapath among C_NUM_INPUTS requesters. It sits upstream of the 64→256 width converter, so that the MAC/DMA streams can time-share a single converter instance. A grant is held for a whole packet, released on the tlast beat, and passed to the next requester in rotation. The data path is combinational; the arbitration state is registered.

## Interface
Parameters:
- C_NUM_INPUTS, 4, number of slave streams (2..8)
- C_AXIS_DATA_WIDTH, 64, tdata width per stream
- C_AXIS_TUSER_WIDTH, 128, tuser width per stream

Ports:
- axi_aclk  in  1  clock; all logic is on the rising edge
- axi_resetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  N*64  flattened; stream i occupies bits [i*64 +: 64]
- s_axis_tstrb  in  N*8  flattened byte strobes
- s_axis_tuser  in  N*128  flattened sideband (len/spt/dpt), passed unchanged
- s_axis_tvalid  in  N  per-stream valid
- s_axis_tready  out  N  per-stream ready
- s_axis_tlast  in  N  per-stream last
- m_axis_tdata  out  64  granted stream data
- m_axis_tstrb  out  8  granted stream strobes
- m_axis_tuser  out  128  granted stream tuser
- m_axis_tvalid  out  1  granted stream valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  granted stream last

## Operation
- State machine with two states, IDLE and GRANT. Registers: state, grant index (gnt, clog2(N) bits), last-served index (last).
- IDLE:
  - Search s_axis_tvalid starting at (last+1) mod N and wrap around. The first set bit wins.
  - On a hit, latch gnt, set last = gnt, and go to GRANT.
  - With no valid input, stay in IDLE.
  - In IDLE, m_axis_tvalid=0 and all s_axis_tready=0.
- GRANT:
  - m_axis_tdata/tstrb/tuser/tlast/tvalid = stream gnt.
  - s_axis_tready[gnt] = m_axis_tready; every other s_axis_tready is 0.
- Packet end: when m_axis_tvalid & m_axis_tready & m_axis_tlast, go to IDLE.
- Within a packet, gnt never changes, whatever the other streams do.
- A requester dropping tvalid mid-packet keeps the grant. The output shows tvalid=0 and the block waits.
- Wrap-around: when last=N-1, the search starts at index 0.
- A non-contiguous tstrb is passed through unchecked.

## Timing
- Reset values:
  - state=IDLE, gnt=0, last=N-1, so port 0 has first priority.
  - m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=all 0.
  - m_axis_tdata/tstrb/tuser=0 while in IDLE.
- Arbitration latency: a request seen in IDLE at edge k gives m_axis_tvalid high in cycle k+1.
- Zero-latency pass-through in GRANT: combinational paths from m_axis_tready to s_axis_tready and from s_axis_* to m_axis_*.
- Packet gap: exactly one IDLE bubble cycle between consecutive packets, including back-to-back packets from the same stream. Maximum throughput is L/(L+1) beats per cycle for L-beat packets.
- Single-beat packet (tlast on the first beat): the grant lasts one cycle if ready is high, followed by one IDLE cycle.
- Reset asserted mid-packet:
  - All outputs go to their reset values immediately (asynchronous).
  - The partial packet is truncated. Downstream is responsible for recovery.
- Fairness: with all N streams continuously requesting, each stream gets exactly one packet per N grants.

## Configuration
- NF10_AXIS_ARB_PKT_COUNT_EN defined:
  - Adds output port pkt_count, N*32 bits.
  - Counter i increments on the accepted tlast beat of stream i.
  - Counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Not defined: no port and no counter logic. Arbitration behaviour is identical in both builds.

## Test plan
- Reset release, all tvalid=0 → m_axis_tvalid=0 and s_axis_tready=0000 for 20 cycles.
- Only stream 2 sends a 4-beat packet (tdata 0x…01..04), m_axis_tready=1:
  - output tvalid rises one cycle after tvalid2.
  - 4 beats appear in order, tuser equals stream 2's tuser.
  - s_axis_tready=0100 during the packet.
- All 4 streams send 3-beat packets continuously → grant order 0,1,2,3,0,1… with a 1-cycle gap; after 8 packets each stream has exactly 2.
- Stream 0 in a 6-beat packet while stream 1 asserts valid; m_axis_tready toggles 1/0 → no beat of stream 1 appears before stream 0's tlast; no beats lost or duplicated.
- Reset pulsed at beat 2 of a 5-beat packet → m_axis_tvalid=0 within the reset; after release port 0 (last=3) wins first.
- With NF10_AXIS_ARB_PKT_COUNT_EN, stream 3 sends 5 one-beat packets → pkt_count[3]=5, others 0. Preloading the counter to 0xFFFFFFFF via force, then one more packet → it reads 0.
